module_hazard_ctrl: RTL and testbench
=====================================

Name: module_hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage RV32I core.
- Drives the stall (enable) and flush (clear) inputs of the enable/clear stage registers, and selects EX-stage operand forwarding.
- Handles load-use stalls, taken-branch flushes and multi-cycle data-memory wait states through a small FSM with a timeout watchdog.

Parameters:
- TIMEOUT, 16, max consecutive wait cycles in one memory access before the error state is entered.
- CNT_W, 32, width of the performance counters (used only when the optional feature is enabled).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- rs1_d_i, rs2_d_i  in  5  source registers in D
- rs1_e_i, rs2_e_i, rd_e_i  in  5  source and destination registers in E
- rd_m_i, rd_w_i  in  5  destination registers in M and W
- regwrite_m_i, regwrite_w_i  in  1  register-write enables in M and W
- load_e_i  in  1  instruction in E is a load
- pcsrc_e_i  in  1  branch or jump taken in E
- memreq_m_i  in  1  M stage is accessing data memory
- dmem_ready_i  in  1  data memory has completed the access this cycle
- fwd_a_e_o, fwd_b_e_o  out  2  forwarding select: 00 = register file, 10 = M result, 01 = W result
- stall_f_o, stall_d_o, stall_e_o, stall_m_o  out  1  stage hold; stage register enable = ~stall
- flush_d_o, flush_e_o, flush_w_o  out  1  stage clear
- err_o  out  1  sticky memory-timeout error

Behaviour:
- Forwarding (combinational):
  - fwd_a = 10 if regwrite_m & rd_m != 0 & rd_m == rs1_e.
  - Otherwise 01 if regwrite_w & rd_w != 0 & rd_w == rs1_e.
  - Otherwise 00.
  - fwd_b is the same using rs2_e. M has priority over W.
- lwstall = load_e & rd_e != 0 & (rd_e == rs1_d | rd_e == rs2_d) & ~pcsrc_e. A taken branch suppresses lwstall because D holds a wrong-path instruction.
- Stage registers apply clear only while enabled. For that reason a flush is never asserted on a stalled stage.
- FSM states: IDLE, WAIT, ERR. State register and wait counter use async reset; reset state is IDLE with counter 0.
  - IDLE: if memreq_m & ~dmem_ready, go to WAIT and set counter = 1. Otherwise stay.
  - WAIT: if dmem_ready, go to IDLE and set counter = 0. Else if counter == TIMEOUT, go to ERR. Otherwise counter += 1.
  - ERR: terminal until rst_i. err_o = 1.
- mem_stall = (memreq_m & ~dmem_ready) | (state == ERR). It is combinational, so it is valid in the first wait cycle.
- Outputs:
  - stall_f = stall_d = lwstall | mem_stall.
  - stall_e = stall_m = mem_stall.
  - flush_d = pcsrc_e & ~mem_stall.
  - flush_e = (lwstall | pcsrc_e) & ~mem_stall.
  - flush_w = mem_stall, which inserts a bubble so W does not retire stale load data.
- Simultaneous events: mem_stall has priority over everything. lwstall and pcsrc_e are re-evaluated once the stall releases, since E is frozen.
- Reset values: all stall/flush outputs 0, err_o = 0. Forward selects follow the inputs combinationally.
- Reset mid-wait: the FSM returns to IDLE immediately and err_o clears.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds outputs lwstall_cnt_o, memstall_cnt_o and flush_cnt_o, each CNT_W bits wide.
  - Each counter increments by 1 per cycle in which lwstall, mem_stall or pcsrc_e & ~mem_stall (respectively) is 1.
  - Counters saturate at all-ones and reset to 0.
- When undefined, these ports and their logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - typedef enum fwd_sel_t {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10}.
  - typedef enum mem_state_t {IDLE, WAIT, ERR}.
  - constant REG_X0 = 5'd0.
- One sub-module, module_forward_sel. It is purely combinational and instantiated once per operand, taking rs_e, rd_m, rd_w, regwrite_m and regwrite_w.

Test Plan:
- x1 written in M, rs1_e = 1, regwrite_m = 1; x1 also in W -> fwd_a = 10. With rd_m = 0 instead -> fwd_a = 01. With both rd = 0 -> fwd_a = 00.
- load_e = 1, rd_e = 5, rs2_d = 5 -> one cycle with stall_f = stall_d = 1 and flush_e = 1, then all deasserted. Same case with pcsrc_e = 1 -> stall = 0, flush_d = flush_e = 1.
- memreq_m = 1 with dmem_ready low for 3 cycles -> stall_f/d/e/m = 1 and flush_w = 1 for exactly 3 cycles, FSM WAIT -> IDLE, err_o = 0.
- memreq_m = 1 with dmem_ready held low and TIMEOUT = 4 -> FSM enters ERR after the 4th wait cycle, err_o = 1 sticky, all stalls held; assert rst_i -> everything 0 and FSM in IDLE.
- pcsrc_e = 1 during a memory wait -> flush_d = flush_e = 0 while waiting; in the first cycle after dmem_ready, flush_d = flush_e = 1.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls, 3 memory-wait cycles and 1 branch -> counters read 2, 3 and 1. With CNT_W = 2, 5 events -> counter saturates at 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the RV32I pipeline hazard control unit.
// Imported by module_hazard_ctrl and module_forward_sel.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } mem_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // x0 is hardwired to zero, so a write to it never produces a value to forward.
    function automatic logic reg_match(input logic       we,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs);
        return we && (rd != REG_X0) && (rd == rs);
    endfunction

endpackage

// File: rtl/module_hazard_ctrl_forward_sel.sv
// EX-stage operand forwarding select for one source operand.
// Purely combinational; the M stage result has priority over the W stage result.
module module_forward_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic       regwrite_m_i,
    input  logic       regwrite_w_i,
    output fwd_sel_t   fwd_o
);

    // NOTE: assigning a default before any branch keeps this block free of latches.
    always_comb begin
        fwd_o = FWD_RF;
        if (reg_match(regwrite_m_i, rd_m_i, rs_e_i)) begin
            fwd_o = FWD_MEM;
        end else if (reg_match(regwrite_w_i, rd_w_i, rs_e_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/module_hazard_ctrl.sv
// Pipeline hazard control: forwarding, load-use stalls, branch flushes and data-memory wait FSM.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module module_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rs1_d_i,
    input  logic [4:0]       rs2_d_i,
    input  logic [4:0]       rs1_e_i,
    input  logic [4:0]       rs2_e_i,
    input  logic [4:0]       rd_e_i,
    input  logic [4:0]       rd_m_i,
    input  logic [4:0]       rd_w_i,
    input  logic             regwrite_m_i,
    input  logic             regwrite_w_i,
    input  logic             load_e_i,
    input  logic             pcsrc_e_i,
    input  logic             memreq_m_i,
    input  logic             dmem_ready_i,
    output logic [1:0]       fwd_a_e_o,
    output logic [1:0]       fwd_b_e_o,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             stall_e_o,
    output logic             stall_m_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic             flush_w_o,
    output logic             err_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] lwstall_cnt_o,
    output logic [CNT_W-1:0] memstall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    localparam int CW = $clog2(TIMEOUT + 1);

    fwd_sel_t        fwd_a;
    fwd_sel_t        fwd_b;
    logic            lwstall;
    logic            mem_wait;
    logic            mem_stall;
    mem_state_t      state;
    mem_state_t      state_n;
    logic [CW-1:0]   wait_cnt;
    logic [CW-1:0]   wait_cnt_n;

    module_forward_sel u_fwd_a (
        .rs_e_i       (rs1_e_i),
        .rd_m_i       (rd_m_i),
        .rd_w_i       (rd_w_i),
        .regwrite_m_i (regwrite_m_i),
        .regwrite_w_i (regwrite_w_i),
        .fwd_o        (fwd_a)
    );

    module_forward_sel u_fwd_b (
        .rs_e_i       (rs2_e_i),
        .rd_m_i       (rd_m_i),
        .rd_w_i       (rd_w_i),
        .regwrite_m_i (regwrite_m_i),
        .regwrite_w_i (regwrite_w_i),
        .fwd_o        (fwd_b)
    );

    assign fwd_a_e_o = fwd_a;
    assign fwd_b_e_o = fwd_b;

    // A taken branch means D holds a wrong-path instruction, so there is no real dependency.
    assign lwstall = load_e_i && (rd_e_i != REG_X0) &&
                     ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i)) && !pcsrc_e_i;

    assign mem_wait  = memreq_m_i && !dmem_ready_i;
    assign mem_stall = mem_wait || (state == ERR);

    // NOTE: state and counter use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    // wait_cnt holds the number of wait cycles already spent in the current access.
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        unique case (state)
            IDLE: begin
                if (mem_wait) begin
                    state_n    = WAIT;
                    wait_cnt_n = CW'(1);
                end
            end
            WAIT: begin
                if (dmem_ready_i) begin
                    state_n    = IDLE;
                    wait_cnt_n = '0;
                end else if (wait_cnt == CW'(TIMEOUT)) begin
                    state_n = ERR;
                end else begin
                    wait_cnt_n = wait_cnt + CW'(1);
                end
            end
            ERR: begin
                state_n = ERR;
            end
            default: begin
                state_n    = IDLE;
                wait_cnt_n = '0;
            end
        endcase
    end

    // A stage register only clears while enabled, so flushes are masked by mem_stall.
    assign stall_f_o = lwstall || mem_stall;
    assign stall_d_o = lwstall || mem_stall;
    assign stall_e_o = mem_stall;
    assign stall_m_o = mem_stall;
    assign flush_d_o = pcsrc_e_i && !mem_stall;
    assign flush_e_o = (lwstall || pcsrc_e_i) && !mem_stall;
    assign flush_w_o = mem_stall;
    assign err_o     = (state == ERR);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lwstall_cnt;
    logic [CNT_W-1:0] memstall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lwstall_cnt  <= '0;
            memstall_cnt <= '0;
            flush_cnt    <= '0;
        end else begin
            if (lwstall && (lwstall_cnt != '1)) begin
                lwstall_cnt <= lwstall_cnt + CNT_W'(1);
            end
            if (mem_stall && (memstall_cnt != '1)) begin
                memstall_cnt <= memstall_cnt + CNT_W'(1);
            end
            if (pcsrc_e_i && !mem_stall && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign lwstall_cnt_o  = lwstall_cnt;
    assign memstall_cnt_o = memstall_cnt;
    assign flush_cnt_o    = flush_cnt;
`endif

endmodule

// File: tb/tb_module_hazard_ctrl.sv
// Directed self-checking bench for module_hazard_ctrl (TIMEOUT = 4, CNT_W = 2).
// Perf-counter checks are compiled in only when HAZARD_PERF_CNT_EN is defined.
module tb_module_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] rs1_d_i, rs2_d_i, rs1_e_i, rs2_e_i, rd_e_i, rd_m_i, rd_w_i;
    logic       regwrite_m_i, regwrite_w_i, load_e_i, pcsrc_e_i, memreq_m_i, dmem_ready_i;
    logic [1:0] fwd_a_e_o, fwd_b_e_o;
    logic       stall_f_o, stall_d_o, stall_e_o, stall_m_o;
    logic       flush_d_o, flush_e_o, flush_w_o, err_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [1:0] lwstall_cnt_o, memstall_cnt_o, flush_cnt_o;
`endif

    int n_total = 0;
    int n_pass  = 0;

    module_hazard_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rs1_d_i        (rs1_d_i),
        .rs2_d_i        (rs2_d_i),
        .rs1_e_i        (rs1_e_i),
        .rs2_e_i        (rs2_e_i),
        .rd_e_i         (rd_e_i),
        .rd_m_i         (rd_m_i),
        .rd_w_i         (rd_w_i),
        .regwrite_m_i   (regwrite_m_i),
        .regwrite_w_i   (regwrite_w_i),
        .load_e_i       (load_e_i),
        .pcsrc_e_i      (pcsrc_e_i),
        .memreq_m_i     (memreq_m_i),
        .dmem_ready_i   (dmem_ready_i),
        .fwd_a_e_o      (fwd_a_e_o),
        .fwd_b_e_o      (fwd_b_e_o),
        .stall_f_o      (stall_f_o),
        .stall_d_o      (stall_d_o),
        .stall_e_o      (stall_e_o),
        .stall_m_o      (stall_m_o),
        .flush_d_o      (flush_d_o),
        .flush_e_o      (flush_e_o),
        .flush_w_o      (flush_w_o),
        .err_o          (err_o)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .lwstall_cnt_o  (lwstall_cnt_o),
        .memstall_cnt_o (memstall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packs the seven stall/flush outputs as {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w}.
    function automatic logic [31:0] ctl();
        return {25'd0, stall_f_o, stall_d_o, stall_e_o, stall_m_o, flush_d_o, flush_e_o, flush_w_o};
    endfunction

    task automatic clear_inputs();
        rs1_d_i = 5'd0; rs2_d_i = 5'd0; rs1_e_i = 5'd0; rs2_e_i = 5'd0;
        rd_e_i = 5'd0; rd_m_i = 5'd0; rd_w_i = 5'd0;
        regwrite_m_i = 1'b0; regwrite_w_i = 1'b0; load_e_i = 1'b0;
        pcsrc_e_i = 1'b0; memreq_m_i = 1'b0; dmem_ready_i = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        next_cycle();
        rst_i = 1'b0;
        #1;
    endtask

    initial begin
        clear_inputs();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #2;
        check("reset_ctl", ctl(), 32'h00);
        check("reset_err", {31'd0, err_o}, 32'd0);
        regwrite_m_i = 1'b1; rd_m_i = 5'd1; rs1_e_i = 5'd1;
        #1;
        check("reset_fwd_comb", {30'd0, fwd_a_e_o}, 32'd2);
        clear_inputs();
        rst_i = 1'b0;
        next_cycle();

        // Forwarding: M beats W, x0 never forwards.
        regwrite_m_i = 1'b1; rd_m_i = 5'd1; regwrite_w_i = 1'b1; rd_w_i = 5'd1; rs1_e_i = 5'd1;
        #1; check("fwd_a_mem_prio", {30'd0, fwd_a_e_o}, 32'd2);
        rd_m_i = 5'd0;
        #1; check("fwd_a_wb", {30'd0, fwd_a_e_o}, 32'd1);
        rd_w_i = 5'd0;
        #1; check("fwd_a_x0", {30'd0, fwd_a_e_o}, 32'd0);
        regwrite_m_i = 1'b0; rd_m_i = 5'd3; regwrite_w_i = 1'b1; rd_w_i = 5'd3; rs2_e_i = 5'd3;
        #1; check("fwd_b_wb_m_nowrite", {30'd0, fwd_b_e_o}, 32'd1);
        regwrite_m_i = 1'b1; rs1_e_i = 5'd7;
        #1; check("fwd_b_mem", {30'd0, fwd_b_e_o}, 32'd2);
        check("fwd_a_nomatch", {30'd0, fwd_a_e_o}, 32'd0);
        clear_inputs();

        // Load-use stall for one cycle, then the bubble releases it.
        next_cycle();
        load_e_i = 1'b1; rd_e_i = 5'd5; rs2_d_i = 5'd5;
        #1; check("lwstall", ctl(), 32'b1100010);
        next_cycle();
        load_e_i = 1'b0;
        #1; check("lwstall_release", ctl(), 32'h00);
        load_e_i = 1'b1; pcsrc_e_i = 1'b1;
        #1; check("lwstall_branch", ctl(), 32'b0000110);
        rs2_d_i = 5'd0; rs1_d_i = 5'd5; pcsrc_e_i = 1'b0;
        #1; check("lwstall_rs1", ctl(), 32'b1100010);
        rd_e_i = 5'd0; rs1_d_i = 5'd0;
        #1; check("lwstall_x0", ctl(), 32'h00);
        clear_inputs();

        // Three-cycle memory wait, then completion.
        next_cycle();
        memreq_m_i = 1'b1; dmem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; check($sformatf("memwait_%0d", i), ctl(), 32'b1111001);
            next_cycle();
        end
        dmem_ready_i = 1'b1;
        #1; check("memwait_done", ctl(), 32'h00);
        next_cycle();
        memreq_m_i = 1'b0; dmem_ready_i = 1'b0;
        #1; check("memwait_idle", ctl(), 32'h00);
        check("memwait_err", {31'd0, err_o}, 32'd0);

        // Branch during a memory wait is held off until the access completes.
        memreq_m_i = 1'b1; pcsrc_e_i = 1'b1;
        #1; check("branch_in_wait", ctl(), 32'b1111001);
        next_cycle();
        #1; check("branch_in_wait_2", ctl(), 32'b1111001);
        next_cycle();
        dmem_ready_i = 1'b1;
        #1; check("branch_after_wait", ctl(), 32'b0000110);
        next_cycle();
        clear_inputs();
        #1; check("branch_done", ctl(), 32'h00);

        // Timeout: entry edge plus four WAIT cycles, ERR on the fifth edge.
        memreq_m_i = 1'b1;
        repeat (4) next_cycle();
        check("timeout_pre_err", {31'd0, err_o}, 32'd0);
        next_cycle();
        check("timeout_err", {31'd0, err_o}, 32'd1);
        memreq_m_i = 1'b0;
        #1; check("err_holds_stall", ctl(), 32'b1111001);
        repeat (3) next_cycle();
        check("err_sticky", {31'd0, err_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("rst_clears_err", {31'd0, err_o}, 32'd0);
        check("rst_clears_ctl", ctl(), 32'h00);
        next_cycle();
        rst_i = 1'b0;
        next_cycle();
        check("post_rst_idle", ctl(), 32'h00);

        // Reset in the middle of a wait returns straight to IDLE.
        memreq_m_i = 1'b1;
        repeat (2) next_cycle();
        memreq_m_i = 1'b0;
        do_reset();
        repeat (5) next_cycle();
        check("midwait_rst_err", {31'd0, err_o}, 32'd0);
        check("midwait_rst_ctl", ctl(), 32'h00);

`ifdef HAZARD_PERF_CNT_EN
        clear_inputs();
        do_reset();
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            load_e_i = 1'b1; rd_e_i = 5'd5; rs1_d_i = 5'd5;
            next_cycle();
            clear_inputs();
            next_cycle();
        end
        memreq_m_i = 1'b1;
        repeat (3) next_cycle();
        dmem_ready_i = 1'b1;
        next_cycle();
        clear_inputs();
        pcsrc_e_i = 1'b1;
        next_cycle();
        clear_inputs();
        next_cycle();
        check("perf_lwstall", {30'd0, lwstall_cnt_o}, 32'd2);
        check("perf_memstall", {30'd0, memstall_cnt_o}, 32'd3);
        check("perf_flush", {30'd0, flush_cnt_o}, 32'd1);
        load_e_i = 1'b1; rd_e_i = 5'd5; rs1_d_i = 5'd5;
        repeat (3) next_cycle();
        clear_inputs();
        next_cycle();
        check("perf_saturate", {30'd0, lwstall_cnt_o}, 32'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
